vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Timing decoder directly downstream of the VGA h/v pixel counter. Turns raw h_count/v_count
//  into registered pixel-fetch address/request and sync/blank outputs delayed to match the
//  pixel source read latency. Output registers drive the DAC/connector pins with no glitches.
// PARAMETERS
//  H_W       10   width of h_count / pix_x
//  V_W       10   width of v_count / pix_y
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels after active)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_MAX     799  last h_count value of a line (line = H_MAX+1 clocks)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_MAX     524  last v_count value of a frame
//  PIPE_DLY  2    pixel source read latency, cycles (legal range 1..8)
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
// PORTS
//  clk          in   1    pixel clock
//  rst_n        in   1    asynchronous, active-low reset
//  h_count      in   H_W  horizontal position from counter, 0..H_MAX
//  v_count      in   V_W  vertical position from counter, 0..V_MAX
//  pix_req      out  1    fetch strobe: current position is visible
//  pix_x        out  H_W  fetch column (valid when pix_req=1, else 0)
//  pix_y        out  V_W  fetch row (valid when pix_req=1, else 0)
//  video_on     out  1    pixel data on DAC valid; low = blank (drive RGB to 0)
//  hsync        out  1    horizontal sync, polarity HS_POL
//  vsync        out  1    vertical sync, polarity VS_POL
//  line_start   out  1    1-cycle pulse aligned with first clock of each line (h=0)
//  frame_start  out  1    1-cycle pulse aligned with h=0,v=0
// BEHAVIOUR
//  - Reset (async assert, sync release): pix_req=0, pix_x=0, pix_y=0, video_on=0,
//    line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL; all delay-line stages
//    cleared to these same inactive values. Reset mid-frame: outputs inactive immediately.
//  - Decode (combinational from inputs): vis = h<H_ACTIVE && v<V_ACTIVE;
//    hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751);
//    vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491); ls = h==0; fs = h==0&&v==0.
//  - Stage 0 (1 cycle): pix_req<=vis; pix_x<=vis?h:0; pix_y<=vis?v:0. Latency 1 from inputs.
//  - Delay line: {vis,hs,vs,ls,fs} registered at stage 0 and shifted PIPE_DLY further stages;
//    outputs taken from last stage. Total latency of video_on/hsync/vsync/line_start/
//    frame_start = 1+PIPE_DLY cycles, so video_on rises exactly PIPE_DLY cycles after pix_req.
//  - hsync = hs_d ? HS_POL : ~HS_POL; vsync likewise with VS_POL. vsync spans full lines
//    (asserted from h=0 of line 490 through h=H_MAX of line 491, i.e. 2*(H_MAX+1) clocks).
//  - Out-of-range inputs (h>H_MAX or v>V_MAX): treated as non-visible, no sync, no pulses;
//    never produce X or wrap into visible region. No comparison may overflow: compare at
//    max(H_W,V_W)+1 bits.
//  - Block holds no state beyond pipeline regs; a counter jump (e.g. counter reset) simply
//    propagates through the delay line; no recovery sequence needed.
//  - All outputs are direct flop outputs (no logic after final register).
// TESTING
//  1 Reset: hold rst_n=0 with h=100,v=100 -> all outputs at reset values; release, 1 clk later
//    pix_req=1,pix_x=100,pix_y=100; video_on=1 after 3 clks (PIPE_DLY=2).
//  2 Full frame sweep driven by counter model: count video_on=1 clocks = 307200, hsync active
//    clocks per line = 96 at h=656..751 (+3 delay), vsync low exactly 1600 clocks, one frame_start.
//  3 Line edges: h=639->640 on v=10 -> pix_req falls 1 clk later, video_on falls 3 clks later;
//    h=799->0 -> line_start pulse one clock wide, 3 clks after h=0.
//  4 Last visible pixel: h=639,v=479 -> pix_x=639,pix_y=479,pix_req=1; h=0,v=480 -> pix_req=0,
//    pix_x=pix_y=0.
//  5 Out-of-range: h=1000,v=1000 and h=700,v=600 -> pix_req=0, video_on=0, hsync/vsync inactive.
//  6 Async reset mid-vsync (v=490,h=300): assert rst_n=0 between clk edges -> vsync=1 and
//    video_on=0 immediately; PIPE_DLY=1 and HS_POL=1 variants rerun scenarios 2-3.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundles the raw counter position consumed by vga_sync_gen and the
//   fetch/sync/blank outputs it produces.
//   master : counter side  (drives h_count/v_count, observes the outputs)
//   slave  : vga_sync_gen  (reads h_count/v_count, drives the outputs)
//   Signals:
//     h_count, v_count   raw horizontal/vertical position
//     pix_req, pix_x,    pixel-fetch strobe and address (latency 1)
//     pix_y
//     video_on, hsync,   DAC-side blank/sync/pulse outputs (latency 1+PIPE_DLY)
//     vsync, line_start,
//     frame_start
// ---------------------------------------------------------------------------
interface vga_sync_gen_if #(
    parameter int unsigned H_W = 10,
    parameter int unsigned V_W = 10
);
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           pix_req;
    logic [H_W-1:0] pix_x;
    logic [V_W-1:0] pix_y;
    logic           video_on;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;

    modport master (
        output h_count, v_count,
        input  pix_req, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input  h_count, v_count,
        output pix_req, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Timing decoder behind the VGA h/v pixel counter. Decodes the raw position
//   into a registered pixel-fetch request/address and into blank/sync/line/
//   frame outputs delayed by PIPE_DLY extra cycles to line up with the pixel
//   source read latency. Every output is driven straight from a flop.
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous assert, synchronous release, active-low reset
//     bus    vga_sync_gen_if.slave: h_count/v_count in; pix_req, pix_x,
//            pix_y, video_on, hsync, vsync, line_start, frame_start out
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int unsigned H_W      = 10,
    parameter int unsigned V_W      = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_MAX    = 799,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_MAX    = 524,
    parameter int unsigned PIPE_DLY = 2,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.slave  bus
);

    // One spare bit so no boundary constant can overflow the compare width.
    localparam int unsigned CW = ((H_W > V_W) ? H_W : V_W) + 1;

    localparam logic [CW-1:0] C_H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_H_MAX  = CW'(H_MAX);
    localparam logic [CW-1:0] C_V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] C_V_MAX  = CW'(V_MAX);

    // Sync bits are stored already at pin polarity so the last stage can
    // drive the pins with no logic after the flop.
    typedef struct packed {
        logic vis;
        logic hsync;
        logic vsync;
        logic ls;
        logic fs;
    } dly_t;

    localparam dly_t DLY_RST = '{vis: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL, ls: 1'b0, fs: 1'b0};

    logic [CW-1:0]  h_w;
    logic [CW-1:0]  v_w;
    logic           in_range;
    logic           vis;
    logic           hs;
    logic           vs;
    logic           ls;
    logic           fs;

    logic           pix_req_d;
    logic [H_W-1:0] pix_x_d;
    logic [V_W-1:0] pix_y_d;
    dly_t           stage_d;

    logic           pix_req_q;
    logic [H_W-1:0] pix_x_q;
    logic [V_W-1:0] pix_y_q;
    dly_t           dly_q [0:PIPE_DLY];

    assign h_w = CW'(bus.h_count);
    assign v_w = CW'(bus.v_count);

    always_comb begin
        in_range = (h_w <= C_H_MAX) && (v_w <= C_V_MAX);
        vis      = in_range && (h_w < C_H_ACT) && (v_w < C_V_ACT);
        hs       = in_range && (h_w >= C_HS_BEG) && (h_w < C_HS_END);
        vs       = in_range && (v_w >= C_VS_BEG) && (v_w < C_VS_END);
        ls       = in_range && (h_w == '0);
        fs       = ls && (v_w == '0);

        pix_req_d = vis;
        pix_x_d   = vis ? bus.h_count : '0;
        pix_y_d   = vis ? bus.v_count : '0;

        stage_d       = DLY_RST;
        stage_d.vis   = vis;
        stage_d.hsync = hs ? HS_POL : ~HS_POL;
        stage_d.vsync = vs ? VS_POL : ~VS_POL;
        stage_d.ls    = ls;
        stage_d.fs    = fs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            for (int unsigned i = 0; i <= PIPE_DLY; i++) begin
                dly_q[i] <= DLY_RST;
            end
        end else begin
            pix_req_q <= pix_req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            dly_q[0]  <= stage_d;
            for (int unsigned i = 1; i <= PIPE_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign bus.pix_req     = pix_req_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.video_on    = dly_q[PIPE_DLY].vis;
    assign bus.hsync       = dly_q[PIPE_DLY].hsync;
    assign bus.vsync       = dly_q[PIPE_DLY].vsync;
    assign bus.line_start  = dly_q[PIPE_DLY].ls;
    assign bus.frame_start = dly_q[PIPE_DLY].fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Drives two instances side by side from the same h/v stimulus:
//     A: defaults (PIPE_DLY=2, active-low syncs)
//     B: PIPE_DLY=1, HS_POL=1, VS_POL=1
//   Expected outputs come from a history of the applied positions and the
//   640x480 timing rules evaluated with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen_if #(.H_W(10), .V_W(10)) ifa ();
    vga_sync_gen_if #(.H_W(10), .V_W(10)) ifb ();

    vga_sync_gen #(.PIPE_DLY(2), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    vga_sync_gen #(.PIPE_DLY(1), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Position history: index 0 = inputs captured at the most recent edge.
    int cur_h = 100;
    int cur_v = 100;
    int hh [16];
    int vv [16];
    bit ok [16];   // 0 = flops were in reset for that capture

    always @(posedge clk) begin
        for (int i = 15; i > 0; i--) begin
            hh[i] = hh[i-1];
            vv[i] = vv[i-1];
            ok[i] = ok[i-1];
        end
        hh[0] = cur_h;
        vv[0] = cur_v;
        ok[0] = rst_n;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 16; i++) ok[i] = 1'b0;
    end

    // Expected {pix_req, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start}
    function automatic logic [25:0] model(input int ph, input int pv, input bit pok,
                                          input int dh, input int dv, input bit dok,
                                          input bit hp, input bit vp);
        bit req, von, hsa, vsa, lsp, fsp, inr;
        int x, y;
        req = pok && ph < 640 && pv < 480;
        x   = req ? ph : 0;
        y   = req ? pv : 0;
        inr = dh <= 799 && dv <= 524;
        von = dok && inr && dh < 640 && dv < 480;
        hsa = dok && inr && dh >= 656 && dh < 752;
        vsa = dok && inr && dv >= 490 && dv < 492;
        lsp = dok && inr && dh == 0;
        fsp = lsp && dv == 0;
        return {req, 10'(x), 10'(y), von, (hsa ? hp : ~hp), (vsa ? vp : ~vp), lsp, fsp};
    endfunction

    function automatic logic [25:0] obs_a();
        return {ifa.pix_req, ifa.pix_x, ifa.pix_y, ifa.video_on, ifa.hsync, ifa.vsync,
                ifa.line_start, ifa.frame_start};
    endfunction

    function automatic logic [25:0] obs_b();
        return {ifb.pix_req, ifb.pix_x, ifb.pix_y, ifb.video_on, ifb.hsync, ifb.vsync,
                ifb.line_start, ifb.frame_start};
    endfunction

    // Sweep-window event counters.
    bit cnt_en = 1'b0;
    int von_a = 0, hs_a = 0, vs_a = 0, ls_a = 0, fs_a = 0;
    int von_b = 0, hs_b = 0, vs_b = 0, ls_b = 0, fs_b = 0;

    always @(negedge clk) begin
        chk("cycle_A", 32'(obs_a()), 32'(model(hh[0], vv[0], ok[0], hh[2], vv[2], ok[2], 1'b0, 1'b0)));
        chk("cycle_B", 32'(obs_b()), 32'(model(hh[0], vv[0], ok[0], hh[1], vv[1], ok[1], 1'b1, 1'b1)));
        if (cnt_en) begin
            von_a += int'(ifa.video_on);   von_b += int'(ifb.video_on);
            hs_a  += int'(ifa.hsync == 1'b0); hs_b += int'(ifb.hsync == 1'b1);
            vs_a  += int'(ifa.vsync == 1'b0); vs_b += int'(ifb.vsync == 1'b1);
            ls_a  += int'(ifa.line_start); ls_b += int'(ifb.line_start);
            fs_a  += int'(ifa.frame_start); fs_b += int'(ifb.frame_start);
        end
    end

    task automatic drive(input int h, input int v, input int n);
        cur_h = h;
        cur_v = v;
        ifa.h_count = 10'(h);
        ifa.v_count = 10'(v);
        ifb.h_count = 10'(h);
        ifb.v_count = 10'(v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rh, rv;

    initial begin
        drive(100, 100, 0);

        // Reset held with a visible position applied: everything inactive.
        repeat (3) @(negedge clk);
        chk("rst_A", 32'(obs_a()), 32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'b00}));
        chk("rst_B", 32'(obs_b()), 32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00}));
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("rel_pix_req", 32'(ifa.pix_req), 32'd1);
            chk("rel_von_A", 32'(ifa.video_on), (k >= 3) ? 32'd1 : 32'd0);
            chk("rel_von_B", 32'(ifb.video_on), (k >= 2) ? 32'd1 : 32'd0);
        end
        chk("rel_pix_xy", 32'({ifa.pix_x, ifa.pix_y}), 32'({10'd100, 10'd100}));

        // Boundary positions: last visible pixel, first blank line, out of range, line edges.
        drive(639, 479, 1);
        drive(0, 480, 1);
        drive(1000, 1000, 1);
        drive(700, 600, 1);
        drive(639, 10, 1);
        drive(640, 10, 4);
        drive(799, 10, 1);
        drive(0, 11, 4);
        drive(900, 600, 12);

        // Counter-driven sweep: lines 470..524 then wrap into lines 0..1.
        cnt_en = 1'b1;
        for (int v = 470; v <= 526; v++) begin
            for (int h = 0; h <= 799; h++) begin
                drive(h, (v > 524) ? v - 525 : v, 1);
            end
        end
        drive(900, 600, 12);
        cnt_en = 1'b0;
        chk("sweep_von_A", 32'(von_a), 32'd7680);
        chk("sweep_von_B", 32'(von_b), 32'd7680);
        chk("sweep_hs_A", 32'(hs_a), 32'd5472);
        chk("sweep_hs_B", 32'(hs_b), 32'd5472);
        chk("sweep_vs_A", 32'(vs_a), 32'd1600);
        chk("sweep_vs_B", 32'(vs_b), 32'd1600);
        chk("sweep_ls_A", 32'(ls_a), 32'd57);
        chk("sweep_ls_B", 32'(ls_b), 32'd57);
        chk("sweep_fs_A", 32'(fs_a), 32'd1);
        chk("sweep_fs_B", 32'(fs_b), 32'd1);

        // Free-running counter with random jumps anywhere in the 10-bit space.
        rh = 0;
        rv = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                rh = int'($urandom_range(0, 1023));
                rv = int'($urandom_range(0, 1023));
            end else if (rh == 799 || rh == 1023) begin
                rh = 0;
                rv = (rv == 524 || rv == 1023) ? 0 : rv + 1;
            end else begin
                rh = rh + 1;
            end
            drive(rh, rv, 1);
        end

        // Asynchronous reset in the middle of vsync: pins go inactive at once.
        drive(300, 490, 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vs_A", 32'(ifa.vsync), 32'd1);
        chk("arst_vs_B", 32'(ifb.vsync), 32'd0);
        chk("arst_von_A", 32'(ifa.video_on), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Asynchronous reset while visible: video_on and pix_req drop at once.
        drive(200, 200, 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vis_A", 32'(obs_a()), 32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 2'b00}));
        chk("arst_vis_B", 32'(obs_b()), 32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00}));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(639, 479, 6);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
